briey_prog_loader: RTL and testbench
====================================

BRIEY_PROG_LOADER -- requirements
Module: briey_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, 15, byte-address width of the Briey RAM load port.
REQ-002 SHALL have parameter CNT_W, 10, width of the line-count and progress fields.
REQ-003 SHALL have port axi4_mm_clk, in, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port axi4_mm_rst_n, in, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port start, in, 1, one-cycle pulse that begins a load.
REQ-006 SHALL have port abort, in, 1, one-cycle pulse that cancels a load.
REQ-007 SHALL have port base_addr, in, ADDR_W, byte address of the first line (64-B aligned, bits[5:0] ignored).
REQ-008 SHALL have port num_lines, in, CNT_W, number of 512-bit lines to load.
REQ-009 SHALL have ports s_valid in 1, s_ready out 1, s_data in 64: the program word stream.
REQ-010 SHALL have ports program_load_en out 1, program_load_aw_valid out 1, program_load_aw_ready in 1, program_load_aw_payload_addr out ADDR_W.
REQ-011 SHALL have ports program_load_w_valid out 1, program_load_w_ready in 1, program_load_w_payload_data out 512, program_load_w_payload_strb out 64.
REQ-012 SHALL have ports busy out 1, done out 1, lines_done out CNT_W, cksum out 32: status.

Function
REQ-013 SHALL implement the states IDLE, FILL, ISSUE and DONE.
REQ-014 IDLE/DONE: start with num_lines!=0 SHALL latch base_addr (bits[5:0] zeroed) and num_lines, clear lines_done, set done=0, and enter FILL.
REQ-015 start with num_lines==0 SHALL enter DONE directly with done=1 and no RAM traffic.
REQ-016 start SHALL be ignored in FILL and ISSUE.
REQ-017 FILL: s_ready=1; each s_valid&&s_ready beat SHALL write s_data into data bits [64*idx +: 64], where idx counts 0..7; the first word is the least significant.
REQ-018 The beat at idx==7 SHALL move the FSM to ISSUE, with aw_valid and w_valid both 1 in the next cycle.
REQ-019 ISSUE: s_ready=0; aw_valid SHALL hold until aw_ready and w_valid SHALL hold until w_ready, each independently; data, addr and strb SHALL stay stable.
REQ-020 ISSUE SHALL exit on the cycle both handshakes have completed (same cycle or different cycles).
REQ-021 On ISSUE exit: lines_done+=1 and addr+=64, with addr wrapping modulo 2^ADDR_W.
REQ-022 On ISSUE exit, if lines_done reaches num_lines the FSM SHALL go to DONE; otherwise it SHALL go to FILL with idx=0.
REQ-023 program_load_w_payload_strb SHALL be all-ones.
REQ-024 program_load_en SHALL be 1 exactly in FILL and ISSUE.
REQ-025 busy SHALL be 1 exactly in FILL and ISSUE.
REQ-026 done SHALL be 1 only in DONE and SHALL be held until the next start.
REQ-027 abort in FILL SHALL discard the partial line and go to IDLE in the next cycle.
REQ-028 abort in ISSUE SHALL let the outstanding valids complete their handshakes, then go to IDLE without incrementing.
REQ-029 An aborted load SHALL never assert done.
REQ-030 abort in IDLE or DONE SHALL move the FSM to IDLE and clear done.
REQ-031 start and abort in the same cycle: abort SHALL win.

Reset
REQ-032 Reset SHALL force IDLE and set idx, addr, lines_done, data and cksum to 0.
REQ-033 During reset all valid, ready and status outputs SHALL be 0: s_ready, program_load_en, program_load_aw_valid, program_load_w_valid, busy and done.
REQ-034 Reset mid-load SHALL drop valids immediately; the partial load is lost and there is no resume.

Configuration
REQ-035 With BRIEY_PROG_LOADER_CKSUM_EN defined, cksum SHALL equal the 32-bit wrapping sum of s_data[31:0]+s_data[63:32] over every accepted beat, cleared on start.
REQ-036 Without BRIEY_PROG_LOADER_CKSUM_EN, cksum SHALL be tied to 0 and no checksum logic SHALL exist.

Structure
REQ-037 Package briey_pkg SHALL hold the loader state enum and the constants LINE_WORDS=8, LINE_BYTES=64 and WORD_W=64.
REQ-038 Sub-module briey_line_packer SHALL implement the 64-to-512 packing register and idx counter, with a clear input and a full output.

Verification
REQ-039 Bench SHALL cover the nominal load: base=0x0100, num_lines=2, 16 words 0..15, aw/w_ready=1 -> aw addrs 0x0100 then 0x0140; line0 data[63:0]=0, data[511:448]=7; done=1, lines_done=2.
REQ-040 Bench SHALL cover skewed handshakes: aw_ready delayed 3 cycles, w_ready immediate -> w_valid drops after 1 cycle, aw_valid stays high 4 cycles, one increment, then FILL.
REQ-041 Bench SHALL cover wrap: base=0x7FC0, num_lines=2 -> addrs 0x7FC0 then 0x0000.
REQ-042 Bench SHALL cover abort: abort after 3 FILL beats -> IDLE next cycle, done=0, no aw_valid; abort in ISSUE with aw_ready=0 -> aw_valid held until aw_ready, then IDLE, lines_done unchanged.
REQ-043 Bench SHALL cover the zero-length and busy cases: num_lines=0 start -> done=1 next cycle, no valids; start during FILL -> ignored.
REQ-044 Bench SHALL cover the checksum: with BRIEY_PROG_LOADER_CKSUM_EN, 8 words 0x00000001_00000002 -> cksum=0x18; without the macro, cksum=0.

Source files
------------

// File: rtl/briey_pkg.sv
// briey_pkg: shared types and constants for the Briey program loader.
package briey_pkg;

   localparam int LINE_WORDS = 8;
   localparam int LINE_BYTES = 64;
   localparam int WORD_W     = 64;
   localparam int LINE_W     = LINE_WORDS * WORD_W;
   localparam int IDX_W      = $clog2(LINE_WORDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } loader_state_e;

endpackage

// File: rtl/briey_line_packer.sv
// briey_line_packer: gathers eight 64-bit words into one 512-bit line.
// The first word lands in the least significant slot. full is high while
// the next accepted word is the last one of the line.
import briey_pkg::*;

module briey_line_packer (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   output logic [LINE_W-1:0] line,
   output logic              full
);

   logic [IDX_W-1:0] idx;

   // word index; wraps 7->0 naturally so the next line starts at slot 0
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       idx <= '0;
      else if (clear)  idx <= '0;
      else if (wr_en)  idx <= idx + 1'b1;
   end

   // line register; only the addressed slot is written
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                  line <= '0;
      else if (wr_en && !clear)   line[{idx, 6'd0} +: WORD_W] <= wr_data;
   end

   assign full = (idx == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/briey_prog_loader.sv
// briey_prog_loader: streams 64-bit program words, packs them into 512-bit
// lines and writes each line to the Briey RAM load port at consecutive
// 64-byte addresses. Optional running checksum under the macro
// BRIEY_PROG_LOADER_CKSUM_EN (tied to zero when undefined).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A source holds valid and its payload stable until that edge and
// never withdraws valid early; ready may change freely.
import briey_pkg::*;

module briey_prog_loader #(
   parameter int ADDR_W = 15,
   parameter int CNT_W  = 10
) (
   input  logic                  axi4_mm_clk,
   input  logic                  axi4_mm_rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [CNT_W-1:0]      num_lines,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [WORD_W-1:0]     s_data,
   output logic                  program_load_en,
   output logic                  program_load_aw_valid,
   input  logic                  program_load_aw_ready,
   output logic [ADDR_W-1:0]     program_load_aw_payload_addr,
   output logic                  program_load_w_valid,
   input  logic                  program_load_w_ready,
   output logic [LINE_W-1:0]     program_load_w_payload_data,
   output logic [LINE_BYTES-1:0] program_load_w_payload_strb,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      lines_done,
   output logic [31:0]           cksum,
   output loader_state_e         dbg_state
);

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  num_q, lines_q;
   logic              aw_pend_q, w_pend_q, abort_pend_q;
   logic              load_go, line_inc, enter_issue, pk_clear, beat, full;
   logic              aw_fire, w_fire;

   assign beat    = s_valid && (state_q == FILL) && !abort;
   assign aw_fire = program_load_aw_valid && program_load_aw_ready;
   assign w_fire  = program_load_w_valid && program_load_w_ready;

   briey_line_packer u_packer (
      .clk     (axi4_mm_clk),
      .rstn    (axi4_mm_rst_n),
      .clear   (pk_clear),
      .wr_en   (beat),
      .wr_data (s_data),
      .line    (program_load_w_payload_data),
      .full    (full)
   );

   // state register
   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) state_q <= IDLE;
      else                state_q <= state_d;
   end

   // next state and state-decoded outputs; abort wins over start
   always_comb begin
      state_d               = state_q;
      s_ready               = 1'b0;
      program_load_en       = 1'b0;
      busy                  = 1'b0;
      done                  = 1'b0;
      program_load_aw_valid = 1'b0;
      program_load_w_valid  = 1'b0;
      load_go               = 1'b0;
      line_inc              = 1'b0;
      enter_issue           = 1'b0;
      pk_clear              = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (abort) begin
               state_d = IDLE;
            end else if (start) begin
               load_go  = 1'b1;
               pk_clear = 1'b1;
               state_d  = (num_lines == '0) ? DONE : FILL;
            end
         end
         FILL: begin
            s_ready         = 1'b1;
            program_load_en = 1'b1;
            busy            = 1'b1;
            if (abort) begin
               pk_clear = 1'b1;
               state_d  = IDLE;
            end else if (s_valid && full) begin
               enter_issue = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            program_load_en       = 1'b1;
            busy                  = 1'b1;
            program_load_aw_valid = aw_pend_q;
            program_load_w_valid  = w_pend_q;
            if ((!aw_pend_q || program_load_aw_ready) &&
                (!w_pend_q  || program_load_w_ready)) begin
               if (abort || abort_pend_q) begin
                  state_d = IDLE;
               end else begin
                  line_inc = 1'b1;
                  state_d  = (lines_q + CNT_W'(1) == num_q) ? DONE : FILL;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // load context, line progress and per-channel outstanding flags
   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) begin
         addr_q       <= '0;
         num_q        <= '0;
         lines_q      <= '0;
         aw_pend_q    <= 1'b0;
         w_pend_q     <= 1'b0;
         abort_pend_q <= 1'b0;
      end else begin
         if (load_go) begin
            addr_q  <= base_addr & ~ADDR_W'(LINE_BYTES - 1);
            num_q   <= num_lines;
            lines_q <= '0;
         end else if (line_inc) begin
            addr_q  <= addr_q + ADDR_W'(LINE_BYTES);
            lines_q <= lines_q + CNT_W'(1);
         end
         if (enter_issue) begin
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
         end else begin
            if (aw_fire) aw_pend_q <= 1'b0;
            if (w_fire)  w_pend_q  <= 1'b0;
         end
         if (state_q != ISSUE) abort_pend_q <= 1'b0;
         else if (abort)       abort_pend_q <= 1'b1;
      end
   end

`ifdef BRIEY_PROG_LOADER_CKSUM_EN
   logic [31:0] cksum_q;

   // running sum of both halves of every accepted word; restarts per load
   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) cksum_q <= '0;
      else if (load_go)   cksum_q <= '0;
      else if (beat)      cksum_q <= cksum_q + s_data[31:0] + s_data[63:32];
   end

   assign cksum = cksum_q;
`else
   assign cksum = '0;
`endif

   assign program_load_aw_payload_addr = addr_q;
   assign program_load_w_payload_strb  = '1;
   assign lines_done                   = lines_q;
   assign dbg_state                    = state_q;

endmodule

// File: tb/tb_briey_prog_loader.sv
// tb_briey_prog_loader: scoreboard bench for briey_prog_loader.
import briey_pkg::*;

module tb_briey_prog_loader;

   localparam int ADDR_W = 15;
   localparam int CNT_W  = 10;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start = 1'b0;
   logic                  abort = 1'b0;
   logic [ADDR_W-1:0]     base_addr = '0;
   logic [CNT_W-1:0]      num_lines = '0;
   logic                  s_valid = 1'b0;
   logic                  s_ready;
   logic [63:0]           s_data = '0;
   logic                  load_en;
   logic                  aw_valid;
   logic                  aw_ready = 1'b0;
   logic [ADDR_W-1:0]     aw_addr;
   logic                  w_valid;
   logic                  w_ready = 1'b0;
   logic [511:0]          w_data;
   logic [63:0]           w_strb;
   logic                  busy;
   logic                  done;
   logic [CNT_W-1:0]      lines_done;
   logic [31:0]           cksum;
   loader_state_e         dbg_state;

   int total = 0;
   int bad   = 0;

   logic [ADDR_W-1:0] exp_aw_q[$];
   logic [511:0]      exp_w_q[$];
   logic [ADDR_W-1:0] exp_a;
   logic [511:0]      exp_d;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   briey_prog_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .axi4_mm_clk                  (clk),
      .axi4_mm_rst_n                (rst_n),
      .start                        (start),
      .abort                        (abort),
      .base_addr                    (base_addr),
      .num_lines                    (num_lines),
      .s_valid                      (s_valid),
      .s_ready                      (s_ready),
      .s_data                       (s_data),
      .program_load_en              (load_en),
      .program_load_aw_valid        (aw_valid),
      .program_load_aw_ready        (aw_ready),
      .program_load_aw_payload_addr (aw_addr),
      .program_load_w_valid         (w_valid),
      .program_load_w_ready         (w_ready),
      .program_load_w_payload_data  (w_data),
      .program_load_w_payload_strb  (w_strb),
      .busy                         (busy),
      .done                         (done),
      .lines_done                   (lines_done),
      .cksum                        (cksum),
      .dbg_state                    (dbg_state)
   );

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (aw_valid && aw_ready) begin
            total++;
            if (exp_aw_q.size() == 0) begin
               bad++;
               $display("FAIL aw_unexpected: got addr=%h, required no aw transfer", aw_addr);
            end else begin
               exp_a = exp_aw_q.pop_front();
               if (aw_addr !== exp_a) begin
                  bad++;
                  $display("FAIL aw_addr: got %h required %h", aw_addr, exp_a);
               end
            end
         end
         if (w_valid && w_ready) begin
            total++;
            if (exp_w_q.size() == 0) begin
               bad++;
               $display("FAIL w_unexpected: got data=%h, required no w transfer", w_data);
            end else begin
               exp_d = exp_w_q.pop_front();
               if (w_data !== exp_d || w_strb !== '1) begin
                  bad++;
                  $display("FAIL w_data: got %h strb=%h required %h strb=all-ones", w_data, w_strb, exp_d);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
      base_addr = b;
      num_lines = n;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic push_word(input logic [63:0] w);
      int n = 0;
      s_valid = 1'b1;
      s_data  = w;
      @(negedge clk);
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         total++;
         bad++;
         $display("FAIL push_timeout: s_ready=%b required 1 within 100 cycles", s_ready);
      end
      tick();
      s_valid = 1'b0;
   endtask

   // one full line; the expected line is queued as the words are driven
   task automatic push_line(input logic [63:0] first, input logic [63:0] step, input bit rnd);
      logic [511:0] line;
      logic [63:0]  w;
      line = '0;
      for (int i = 0; i < 8; i++) begin
         w = rnd ? {$urandom(), $urandom()} : first + step * 64'(i);
         line[i*64 +: 64] = w;
         if (i == 7) exp_w_q.push_back(line);
         push_word(w);
      end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      @(negedge clk);
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL done_timeout: done=%b required 1 within %0d cycles", done, budget);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({s_ready, load_en, aw_valid, w_valid, busy, done} !== 6'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b required 000000",
                  {s_ready, load_en, aw_valid, w_valid, busy, done});
      end
      total++;
      if (lines_done !== '0 || cksum !== '0 || w_data !== '0 || aw_addr !== '0) begin
         bad++;
         $display("FAIL reset_regs: lines=%h cksum=%h addr=%h required all zero", lines_done, cksum, aw_addr);
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (dbg_state !== IDLE || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: state=%0d busy=%b required IDLE busy=0", dbg_state, busy);
      end
   endtask

   task automatic test_nominal();
      tick();
      aw_ready = 1'b1;
      w_ready  = 1'b1;
      exp_aw_q.push_back(15'h0100);
      exp_aw_q.push_back(15'h0140);
      pulse_start(15'h0100, 10'd2);
      push_line(64'd0, 64'd1, 1'b0);
      push_line(64'd8, 64'd1, 1'b0);
      wait_done(50);
      total++;
      if (lines_done !== 10'd2 || busy !== 1'b0 || dbg_state !== DONE) begin
         bad++;
         $display("FAIL nominal_status: lines=%0d busy=%b state=%0d required 2 0 DONE", lines_done, busy, dbg_state);
      end
      total++;
      if (exp_aw_q.size() != 0 || exp_w_q.size() != 0) begin
         bad++;
         $display("FAIL nominal_drain: aw left=%0d w left=%0d required 0 0", exp_aw_q.size(), exp_w_q.size());
      end
   endtask

   task automatic test_skew();
      int aw_cnt = 0;
      int w_cnt  = 0;
      tick();
      aw_ready = 1'b0;
      w_ready  = 1'b1;
      exp_aw_q.push_back(15'h0000);
      exp_aw_q.push_back(15'h0040);
      pulse_start(15'h0000, 10'd2);
      push_line(64'h100, 64'd1, 1'b0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (aw_valid) aw_cnt++;
         if (w_valid)  w_cnt++;
         if (c == 2) begin
            tick();
            aw_ready = 1'b1;
         end
      end
      total++;
      if (aw_cnt != 4 || w_cnt != 1) begin
         bad++;
         $display("FAIL skew_valid_len: aw cycles=%0d w cycles=%0d required 4 1", aw_cnt, w_cnt);
      end
      total++;
      if (lines_done !== 10'd1 || dbg_state !== FILL) begin
         bad++;
         $display("FAIL skew_progress: lines=%0d state=%0d required 1 FILL", lines_done, dbg_state);
      end
      tick();
      push_line(64'd0, 64'd0, 1'b1);
      wait_done(50);
      total++;
      if (lines_done !== 10'd2) begin
         bad++;
         $display("FAIL skew_done: lines=%0d required 2", lines_done);
      end
   endtask

   task automatic test_wrap();
      tick();
      aw_ready = 1'b1;
      w_ready  = 1'b1;
      exp_aw_q.push_back(15'h7FC0);
      exp_aw_q.push_back(15'h0000);
      pulse_start(15'h7FC0, 10'd2);
      push_line(64'd0, 64'd0, 1'b1);
      push_line(64'd0, 64'd0, 1'b1);
      wait_done(50);
      total++;
      if (exp_aw_q.size() != 0 || lines_done !== 10'd2) begin
         bad++;
         $display("FAIL wrap: aw left=%0d lines=%0d required 0 2", exp_aw_q.size(), lines_done);
      end
   endtask

   task automatic test_abort_fill();
      int aw_seen = 0;
      tick();
      pulse_start(15'h0400, 10'd2);
      push_word(64'hA);
      push_word(64'hB);
      push_word(64'hC);
      pulse_abort();
      @(negedge clk);
      total++;
      if (dbg_state !== IDLE || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_fill_state: state=%0d busy=%b done=%b required IDLE 0 0", dbg_state, busy, done);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (aw_valid || w_valid || done) aw_seen++;
      end
      total++;
      if (aw_seen != 0) begin
         bad++;
         $display("FAIL abort_fill_quiet: active cycles=%0d required 0", aw_seen);
      end
   endtask

   task automatic test_abort_issue();
      tick();
      aw_ready = 1'b1;
      w_ready  = 1'b1;
      exp_aw_q.push_back(15'h0800);
      exp_aw_q.push_back(15'h0840);
      pulse_start(15'h0800, 10'd3);
      push_line(64'd0, 64'd0, 1'b1);
      tick();
      aw_ready = 1'b0;
      push_line(64'd0, 64'd0, 1'b1);
      pulse_abort();
      @(negedge clk);
      total++;
      if (aw_valid !== 1'b1 || dbg_state !== ISSUE) begin
         bad++;
         $display("FAIL abort_issue_hold: aw_valid=%b state=%0d required 1 ISSUE", aw_valid, dbg_state);
      end
      tick();
      aw_ready = 1'b1;
      tick();
      @(negedge clk);
      total++;
      if (dbg_state !== IDLE || lines_done !== 10'd1 || done !== 1'b0 || aw_valid !== 1'b0) begin
         bad++;
         $display("FAIL abort_issue_exit: state=%0d lines=%0d done=%b aw_valid=%b required IDLE 1 0 0",
                  dbg_state, lines_done, done, aw_valid);
      end
      total++;
      if (exp_aw_q.size() != 0 || exp_w_q.size() != 0) begin
         bad++;
         $display("FAIL abort_issue_drain: aw left=%0d w left=%0d required 0 0", exp_aw_q.size(), exp_w_q.size());
      end
   endtask

   task automatic test_zero_len();
      int active = 0;
      tick();
      pulse_start(15'h0100, 10'd0);
      @(negedge clk);
      total++;
      if (done !== 1'b1 || dbg_state !== DONE || lines_done !== 10'd0) begin
         bad++;
         $display("FAIL zero_len_done: done=%b state=%0d lines=%0d required 1 DONE 0", done, dbg_state, lines_done);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (aw_valid || w_valid || busy || s_ready || !done) active++;
      end
      total++;
      if (active != 0) begin
         bad++;
         $display("FAIL zero_len_quiet: bad cycles=%0d required 0", active);
      end
   endtask

   task automatic test_start_busy();
      logic [511:0] line;
      logic [63:0]  w;
      tick();
      aw_ready = 1'b1;
      w_ready  = 1'b1;
      exp_aw_q.push_back(15'h0200);
      pulse_start(15'h0213, 10'd1);
      line = '0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            pulse_start(15'h0300, 10'd5);
            @(negedge clk);
            total++;
            if (dbg_state !== FILL || done !== 1'b0) begin
               bad++;
               $display("FAIL start_in_fill: state=%0d done=%b required FILL 0", dbg_state, done);
            end
            tick();
         end
         w = {$urandom(), $urandom()};
         line[i*64 +: 64] = w;
         if (i == 7) exp_w_q.push_back(line);
         push_word(w);
      end
      wait_done(50);
      total++;
      if (lines_done !== 10'd1 || exp_aw_q.size() != 0) begin
         bad++;
         $display("FAIL start_busy_done: lines=%0d aw left=%0d required 1 0", lines_done, exp_aw_q.size());
      end
   endtask

   task automatic test_reset_midload();
      tick();
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      pulse_start(15'h0100, 10'd1);
      push_line(64'd0, 64'd0, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (aw_valid !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_midload: aw=%b w=%b busy=%b s_ready=%b required 0 0 0 0",
                  aw_valid, w_valid, busy, s_ready);
      end
      exp_aw_q.delete();
      exp_w_q.delete();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (dbg_state !== IDLE || lines_done !== 10'd0 || w_data !== '0) begin
         bad++;
         $display("FAIL reset_midload_state: state=%0d lines=%0d required IDLE 0 and cleared data", dbg_state, lines_done);
      end
   endtask

   task automatic test_cksum();
      logic [31:0] exp_ck;
`ifdef BRIEY_PROG_LOADER_CKSUM_EN
      exp_ck = 32'h18;
`else
      exp_ck = 32'h0;
`endif
      tick();
      aw_ready = 1'b1;
      w_ready  = 1'b1;
      exp_aw_q.push_back(15'h0000);
      pulse_start(15'h0000, 10'd1);
      push_line(64'h00000001_00000002, 64'd0, 1'b0);
      wait_done(50);
      total++;
      if (cksum !== exp_ck) begin
         bad++;
         $display("FAIL cksum: got %h required %h", cksum, exp_ck);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_nominal();
      test_skew();
      test_wrap();
      test_abort_fill();
      test_abort_issue();
      test_zero_len();
      test_start_busy();
      test_reset_midload();
      test_cksum();
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
